// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch stage for the 8-bit controller. Holds a loadable
//   256-word program memory and the fetch PC, prefetches words into a small
//   queue and presents the head over a valid/ready handshake. The controller
//   can redirect the fetch PC (jump/return) or halt fetching until reset.
//
// Parameters
//   DEPTH      prefetch queue entries (power of two, >= 2)
//   MEM_WORDS  program memory words (address width fixed at 8 bits)
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   prog_we/addr/data     program memory write port (accepted in every state)
//   run                   fetch enable
//   redirect/redirect_pc  one-cycle pulse: new fetch PC, flush queue
//   halt                  one-cycle pulse: flush and stop until reset
//   instr_ready           consumer accepts the head instruction
//   instr, instr_pc       head word and its address (0 when empty)
//   instr_valid           queue non-empty
//   fetch_pc              address of the next memory read
//   queue_level           occupied queue entries
//   halted                unit is in the HALTED state
//   retired_cnt           saturating pop counter (IFU_PERF_CNT_EN only)
//
// Build option
//   IFU_PERF_CNT_EN  adds the 16-bit saturating retired_cnt output.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    prog_we,
  input  logic [7:0]              prog_addr,
  input  logic [7:0]              prog_data,
  input  logic                    run,
  input  logic                    redirect,
  input  logic [7:0]              redirect_pc,
  input  logic                    halt,
  input  logic                    instr_ready,
  output logic [7:0]              instr,
  output logic [7:0]              instr_pc,
  output logic                    instr_valid,
  output logic [7:0]              fetch_pc,
  output logic [$clog2(DEPTH):0]  queue_level,
  output logic                    halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]             retired_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_e;

  state_e          state_q, state_d;
  logic [7:0]      fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [7:0]      rd_pc_q, rd_pc_d;
  logic [7:0]      rd_data_q;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      instr_q, instr_d;
  logic [7:0]      instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;

  logic [7:0]      mem [MEM_WORDS];
  logic [7:0]      q_data_q [DEPTH];
  logic [7:0]      q_pc_q [DEPTH];

  logic            pop, push, take_redirect, flush, issue;
  logic [CW-1:0]   occupancy, remain;

  assign pop           = instr_valid_q & instr_ready;
  // halt beats redirect, and a halted unit ignores redirects entirely.
  assign take_redirect = redirect & ~halt & (state_q != HALTED);
  assign flush         = halt | take_redirect;
  // A read landing in a flush cycle belongs to the abandoned stream.
  assign push          = inflight_q & ~flush;
  assign occupancy     = count_q + CW'(inflight_q);
  assign remain        = count_q - CW'(pop);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rd_pc_d       = rd_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    instr_d       = '0;
    instr_pc_d    = '0;
    instr_valid_d = 1'b0;
    issue         = 1'b0;

    if (halt || state_q == HALTED) state_d = HALTED;
    else                           state_d = run ? FETCH : IDLE;

    // Issue is keyed off the state being entered so fetching starts in the
    // very cycle run rises. Reserving a slot for the in-flight read
    // guarantees the landing word always has room.
    issue      = (state_d == FETCH) && !flush && (occupancy < CW'(DEPTH));
    inflight_d = issue;
    if (issue) rd_pc_d = fetch_pc_q;

    if (take_redirect) fetch_pc_d = redirect_pc;
    else if (issue)    fetch_pc_d = fetch_pc_q + 8'd1;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Registered head: pick what the head will be after this edge. If the
    // queue drains to nothing but a word lands, that word bypasses storage.
    if (count_d != '0) begin
      instr_valid_d = 1'b1;
      if (remain == '0) begin
        instr_d    = rd_data_q;
        instr_pc_d = rd_pc_q;
      end else begin
        instr_d    = q_data_q[rd_ptr_d];
        instr_pc_d = q_pc_q[rd_ptr_d];
      end
    end
  end

  // NOTE: the program memory, its read register and the queue storage carry
  // no reset; their contents are only ever used when qualified by
  // inflight/count, and program contents must survive reset.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    if (issue)   rd_data_q      <= mem[fetch_pc_q];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data_q[wr_ptr_q] <= rd_data_q;
      q_pc_q[wr_ptr_q]   <= rd_pc_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      rd_pc_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      rd_pc_q       <= rd_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign queue_level = count_q;
  assign halted      = (state_q == HALTED);

`ifdef IFU_PERF_CNT_EN
  logic [15:0] retired_q, retired_d;

  // Counts every accepted pop, including one in a redirect/halt cycle.
  always_comb begin
    retired_d = retired_q;
    if (pop && retired_q != 16'hFFFF) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Self-checking bench for instr_fetch_unit. Driver tasks issue stimulus
//   and, whenever a new instruction stream begins (reset or redirect), push
//   the expected stream (address, memory word) into a scoreboard queue. A
//   negedge monitor pops and compares on every accepted handshake. Directed
//   sections add cycle-exact timing checks; a randomized section follows.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic       clk, reset, prog_we, run, redirect, halt, instr_ready;
  logic [7:0] prog_addr, prog_data, redirect_pc;
  logic [7:0] instr, instr_pc, fetch_pc;
  logic       instr_valid, halted;
  logic [2:0] queue_level;
`ifdef IFU_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  instr_fetch_unit #(.DEPTH(DEPTH), .MEM_WORDS(256)) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .run         (run),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fetch_pc    (fetch_pc),
    .queue_level (queue_level),
    .halted      (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] pc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] mem_model [256];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pop_cnt  = 0;
  bit         hold_prev = 1'b0;
  logic [7:0] prev_instr, prev_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: sequential addresses from pc, words as the memory holds
  // them at stream start (random phases never write the memory).
  task automatic sb_restart(input logic [7:0] pc);
    exp_t e;
    logic [7:0] a;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      a      = pc + 8'(i);
      e.pc   = a;
      e.data = mem_model[a];
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard monitor plus handshake invariants.
  always @(negedge clk) begin
    if (reset) begin
      pop_cnt   = 0;
      hold_prev = 1'b0;
    end else begin
      if (!instr_valid) check("empty_outputs_zero", {instr, instr_pc}, 16'h0000);
      if (hold_prev) begin
        check("stall_valid", instr_valid, 1);
        check("stall_instr", instr, prev_instr);
        check("stall_pc", instr_pc, prev_pc);
      end
      if (instr_valid && instr_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_pop: got pc %0h instr %0h, expected no instruction", instr_pc, instr);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_pc", instr_pc, mon_e.pc);
          check("sb_instr", instr, mon_e.data);
        end
      end
      hold_prev  = instr_valid && !instr_ready && !redirect && !halt;
      prev_instr = instr;
      prev_pc    = instr_pc;
    end
  end

  task automatic check_reset_outputs();
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_fetch_pc", fetch_pc, 0);
    check("rst_level", queue_level, 0);
    check("rst_halted", halted, 0);
  endtask

  // Called at posedge+1; returns at the start of cycle 0 after deassertion.
  task automatic do_reset(input bit run_after, input bit ready_after);
    reset    = 1'b1;
    redirect = 1'b0;
    halt     = 1'b0;
    prog_we  = 1'b0;
    exp_q.delete();
    smp();
    check_reset_outputs();
    cyc();
    cyc();
    reset       = 1'b0;
    run         = run_after;
    instr_ready = ready_after;
    sb_restart(8'h00);
  endtask

  // Cycles 0..5 after reset release with run=1, instr_ready=1.
  task automatic first_stream_checks();
    logic [7:0] words [4];
    words[0] = 8'h00; words[1] = 8'h01; words[2] = 8'h05; words[3] = 8'h13;
    for (int c = 0; c < 6; c++) begin
      smp();
      if (c < 2) begin
        check("start_valid_low", instr_valid, 0);
        check("start_fetch_pc", fetch_pc, c);
      end else begin
        check("start_valid", instr_valid, 1);
        check("start_pc", instr_pc, c - 2);
        check("start_instr", instr, words[c-2]);
      end
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] old5, new5, r_pc;
    bit         pend;
    reset = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom_range(0, 255));
    mem_model[0] = 8'h00; mem_model[1] = 8'h01; mem_model[2] = 8'h05; mem_model[3] = 8'h13;

    // Power-on reset, then load the program with run=0.
    cyc(); cyc();
    smp();
    check_reset_outputs();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      prog_we = 1'b1; prog_addr = 8'(i); prog_data = mem_model[i];
      cyc();
    end
    prog_we = 1'b0;
    smp();
    check("idle_valid", instr_valid, 0);
    check("idle_fetch_pc", fetch_pc, 0);
    check("idle_level", queue_level, 0);
    cyc();

    // First words after reset, back to back.
    do_reset(1'b1, 1'b1);
    first_stream_checks();

    // Backpressure fills the queue, then drains without gaps.
    do_reset(1'b1, 1'b0);
    repeat (6) cyc();
    smp();
    check("full_level", queue_level, DEPTH);
    check("full_fetch_pc", fetch_pc, 4);
    check("full_head_pc", instr_pc, 0);
    cyc();
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      check("drain_valid", instr_valid, 1);
      check("drain_pc", instr_pc, k);
      cyc();
    end

    // Redirect to 0x10 with three queued entries.
    do_reset(1'b1, 1'b0);
    repeat (4) cyc();
    redirect = 1'b1; redirect_pc = 8'h10;
    smp();
    check("redir_level_before", queue_level, 3);
    cyc();
    redirect = 1'b0;
    sb_restart(8'h10);
    smp(); check("redir_valid_e1", instr_valid, 0); cyc();
    smp(); check("redir_valid_e2", instr_valid, 0); cyc();
    smp();
    check("redir_valid_e3", instr_valid, 1);
    check("redir_pc", instr_pc, 8'h10);
    check("redir_instr", instr, mem_model[16]);
    cyc();
    instr_ready = 1'b1;
    repeat (3) cyc();

    // Redirect near the top of memory: PC wraps.
    redirect = 1'b1; redirect_pc = 8'hFE;
    cyc();
    redirect = 1'b0;
    sb_restart(8'hFE);
    smp(); cyc();
    smp(); cyc();
    for (int k = 0; k < 4; k++) begin
      smp();
      check("wrap_valid", instr_valid, 1);
      check("wrap_pc", instr_pc, 8'(8'hFE + 8'(k)));
      cyc();
    end

    // halt and redirect together: halt wins. Reads issued at FE..03 leave
    // fetch_pc at 04, which must hold while halted.
    halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
    cyc();
    halt = 1'b0; redirect = 1'b0;
    exp_q.delete();
    smp();
    check("halt_halted", halted, 1);
    check("halt_level", queue_level, 0);
    check("halt_valid", instr_valid, 0);
    check("halt_fetch_pc", fetch_pc, 8'h04);
    cyc();
    redirect = 1'b1; redirect_pc = 8'h20;
    cyc();
    redirect = 1'b0;
    repeat (6) begin
      smp();
      check("halted_valid", instr_valid, 0);
      check("halted_flag", halted, 1);
      check("halted_fetch_pc", fetch_pc, 8'h04);
      cyc();
    end
    do_reset(1'b1, 1'b1);
    first_stream_checks();

    // Write to address 5 in the cycle it is read: old word delivered.
    do_reset(1'b1, 1'b1);
    repeat (5) cyc();
    old5 = mem_model[5];
    new5 = ~old5;
    prog_we = 1'b1; prog_addr = 8'h05; prog_data = new5;
    smp();
    check("rw_fetch_pc", fetch_pc, 8'h05);
    cyc();
    prog_we = 1'b0;
    mem_model[5] = new5;
    smp(); cyc();
    smp();
    check("rw_pc", instr_pc, 8'h05);
    check("rw_old_data", instr, old5);
    cyc();
    redirect = 1'b1; redirect_pc = 8'h05;
    cyc();
    redirect = 1'b0;
    sb_restart(8'h05);
    smp(); cyc();
    smp(); cyc();
    smp();
    check("rw_refetch_pc", instr_pc, 8'h05);
    check("rw_new_data", instr, new5);
    cyc();

    // Randomized run/ready/redirect traffic against the scoreboard.
    pend = 1'b0;
    r_pc = '0;
    for (int n = 0; n < 1500; n++) begin
      if (pend) sb_restart(r_pc);
      run         = ($urandom_range(0, 7) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 8'($urandom_range(0, 255));
      pend        = redirect;
      r_pc        = redirect_pc;
      smp();
      check("level_bound", (queue_level <= 3'(DEPTH)), 1);
      cyc();
    end
    if (pend) sb_restart(r_pc);
    redirect = 1'b0; run = 1'b0; instr_ready = 1'b1;
    repeat (10) cyc();
    smp();
    check("final_drained", instr_valid, 0);
`ifdef IFU_PERF_CNT_EN
    check("retired_cnt", retired_cnt, pop_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Instruction fetch stage feeding the 8-bit controller's `instr` input.
- Holds a loadable program memory and the fetch PC.
- Prefetches into a small queue and presents instructions over a valid/ready handshake.
- Accepts redirects (jump/return targets) and a halt request from the controller.

## Interface
- `DEPTH`, 4 — prefetch queue entries (power of two, ≥2).
- `MEM_WORDS`, 256 — program memory words; address width fixed at 8 bits.
- `clk` in 1 — clock.
- `reset` in 1 — reset, asynchronous, active-high.
- `prog_we` in 1 — program memory write strobe.
- `prog_addr` in 8 — program memory write address.
- `prog_data` in 8 — program memory write data.
- `run` in 1 — fetch enable.
- `redirect` in 1 — one-cycle pulse; load new fetch PC and flush the queue.
- `redirect_pc` in 8 — redirect target.
- `halt` in 1 — one-cycle pulse; stop fetching permanently until reset.
- `instr_ready` in 1 — consumer accepts the head instruction.
- `instr` out 8 — head instruction word; 0 when the queue is empty.
- `instr_pc` out 8 — address of `instr`; 0 when the queue is empty.
- `instr_valid` out 1 — queue non-empty.
- `fetch_pc` out 8 — address of the next memory read.
- `queue_level` out $clog2(DEPTH)+1 — occupied entries.
- `halted` out 1 — in HALTED state.

## Operation
- States:
  - IDLE: `run`=0.
  - FETCH: `run`=1.
  - HALTED: reached from any state on `halt`; left only via `reset`.
- IDLE↔FETCH follows `run` each cycle.
- Memory:
  - Synchronous read, no reset on the array; contents survive `reset`.
  - Writes are accepted in every state.
  - A read and a write to the same address in the same cycle return the old data.
- Read issue: in FETCH when `queue_level + inflight < DEPTH`. `inflight` is 1 if a read was issued in the previous cycle.
- On issue, `fetch_pc` increments by 1 mod 256; `8'hFF` wraps to `8'h00`.
- Read data is pushed to the queue tail with its address one cycle after issue.
- Pop: when `instr_valid && instr_ready`, the head is removed.
  - Push and pop in the same cycle leave `queue_level` unchanged.
- `run` falling: no new issues. An in-flight read still lands in the queue, and the queue keeps draining.
- `redirect`:
  - `fetch_pc` ← `redirect_pc`.
  - Queue emptied and any in-flight read discarded.
  - A pop in the same cycle counts as accepted.
  - Ignored in HALTED.
- `halt`: queue emptied, in-flight read discarded, no further issues, `halted`=1.
- `halt` and `redirect` in the same cycle: `halt` wins.
- Reset values:
  - `instr`, `instr_pc`, `fetch_pc`, `queue_level`: 0.
  - `instr_valid`, `halted`: 0.
  - State: IDLE.
- Reset mid-operation: queue and in-flight read discarded immediately; memory untouched.

## Timing
- Read issued in cycle T. The word enters the queue at the edge ending T+1, and `instr_valid` is visible in T+2.
- After `reset` deasserts with `run`=1: the first read issues in cycle 0 at address 0, and `instr_valid`=1 in cycle 2.
- Steady state with `instr_ready`=1 held: one instruction per cycle, no bubbles.
- `redirect` sampled at edge E:
  - `instr_valid`=0 from E+1.
  - The read of `redirect_pc` issues in the cycle after E.
  - The target instruction is valid 2 cycles later.
- `instr`, `instr_pc` and `instr_valid` are registered. They change only at clock edges and are stable while `instr_valid && !instr_ready`.
- `halted` rises in the cycle after `halt` is sampled.

## Configuration
- `IFU_PERF_CNT_EN` defined:
  - Adds output `retired_cnt` (16 bits, reset 0).
  - Increments by 1 on every pop and saturates at `16'hFFFF`.
  - Unaffected by `redirect` and `halt`.
- `IFU_PERF_CNT_EN` undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- Load addr 0..3 with 8'h00, 8'h01, 8'h05, 8'h13; set `run`=1 with `instr_ready`=1 → words appear in cycles 2..5, `instr_pc` = 0..3, no gaps.
- Hold `instr_ready`=0 → `queue_level` reaches DEPTH (4) and `fetch_pc` stops at 4. Release → 4 words drain back-to-back, then fetch resumes at addr 4.
- Pulse `redirect` with `redirect_pc`=8'h10 while the queue holds 3 entries → `instr_valid`=0 the next cycle; first valid word is mem[16] with `instr_pc`=8'h10, 3 cycles after the pulse.
- `redirect_pc`=8'hFE with `instr_ready`=1 → `instr_pc` sequence FE, FF, 00, 01.
- Pulse `halt` and `redirect` in the same cycle → `halted`=1, queue empty, no further `instr_valid`. Then assert `reset` → all outputs 0 and memory contents intact on the next fetch.
- Write addr 5 in the same cycle it is read → old value delivered; re-fetch after `redirect` to 5 → new value. With `IFU_PERF_CNT_EN` defined, `retired_cnt` equals the number of pops.
